// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mult_pkg
// Brief    : Shared constants and state type for the 4x4 shift-add multiplier.
// Revision : 1.0
// ============================================================================
package mult_pkg;

    localparam int N  = 4;
    localparam int PW = 2 * N;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = IDLE,
        ST_RUN  = RUN,
        ST_DONE = DONE
    } state_t;

endpackage
`default_nettype wire

// File: rtl/shift_add_mult_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : shift_add_mult_ctrl_if
// Brief    : Start/done handshake plus the adder operand/result bundle.
// Revision : 1.0
// ============================================================================
interface shift_add_mult_ctrl_if #(
    parameter int N = mult_pkg::N
);

    logic             start;
    logic [N-1:0]     a;
    logic [N-1:0]     b;
    logic [2*N-1:0]   add_a;
    logic [2*N-1:0]   add_b;
    logic [2*N-1:0]   add_sum;
    logic             add_carry;
    logic             busy;
    logic             done;
    logic [2*N-1:0]   product;
    logic             fault;

    // master: the multiplier top level (requester side and the external adder)
    modport master (
        output start, a, b, add_sum, add_carry,
        input  add_a, add_b, busy, done, product, fault
    );

    // slave: the shift-add controller
    modport slave (
        input  start, a, b, add_sum, add_carry,
        output add_a, add_b, busy, done, product, fault
    );

endinterface
`default_nettype wire

// File: rtl/adder.sv
`default_nettype none
// ============================================================================
// Module   : adder
// Brief    : Unsigned ripple-carry adder shared with the multiplier controller.
// Revision : 1.0
// ============================================================================
module adder #(
    parameter int WIDTH = mult_pkg::PW
) (
    input  wire logic [WIDTH-1:0] a,
    input  wire logic [WIDTH-1:0] b,
    output logic      [WIDTH-1:0] out,
    output logic                  carry_out
);

    logic [WIDTH:0] w_c;

    assign w_c[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign out[i]   = a[i] ^ b[i] ^ w_c[i];
        assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end

    assign carry_out = w_c[WIDTH];

endmodule
`default_nettype wire

// File: rtl/shift_add_mult_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : shift_add_mult_ctrl
// Brief    : Shift-add controller computing an NxN unsigned product through an
//            external 2N-bit adder, one multiplier bit per cycle.
// Revision : 1.0
// ============================================================================
module shift_add_mult_ctrl #(
    parameter int N         = mult_pkg::N,
    parameter bit SKIP_ZERO = 1'b0
) (
    input  wire logic             clk,
    input  wire logic             rst,
    shift_add_mult_ctrl_if.slave  bus
);

    import mult_pkg::*;

    // 2*N must match the adder width; only N=4 is a legal configuration.
    localparam int W  = 2 * N;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    state_t          state_q;
    logic [W-1:0]    acc_q;
    logic [W-1:0]    mcand_q;
    logic [N-1:0]    mult_q;
    logic [CW-1:0]   count_q;
    logic [W-1:0]    product_q;
    logic            busy_q;
    logic            done_q;
    logic            fault_q;

    logic [W-1:0]    mcand_d;
    logic [N-1:0]    mult_d;
    logic [CW-1:0]   count_d;
    logic            last_d;

    assign mcand_d = mcand_q << 1;
    assign mult_d  = mult_q >> 1;
    assign count_d = count_q + 1'b1;
    assign last_d  = (count_q == CW'(N - 1)) || (SKIP_ZERO && (mult_d == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mult_q    <= '0;
            count_q   <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        mcand_q <= {{N{1'b0}}, bus.a};
                        mult_q  <= bus.b;
                        acc_q   <= '0;
                        count_q <= '0;
                        fault_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    acc_q   <= bus.add_sum;
                    mcand_q <= mcand_d;
                    mult_q  <= mult_d;
                    count_q <= count_d;
                    if (bus.add_carry && mult_q[0]) begin
                        fault_q <= 1'b1;
                    end
                    // Product and done are registered on entry so both are
                    // valid throughout the single DONE cycle.
                    if (last_d) begin
                        product_q <= bus.add_sum;
                        done_q    <= 1'b1;
                        state_q   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.add_a   = acc_q;
    assign bus.add_b   = ((state_q == ST_RUN) && mult_q[0]) ? mcand_q : '0;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.product = product_q;
    assign bus.fault   = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_add_mult_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_add_mult_ctrl
// Brief    : Randomized self-checking bench for the shift-add controller,
//            with a plain-arithmetic reference for product and latency.
// Revision : 1.0
// ============================================================================
module tb_shift_add_mult_ctrl;

    import mult_pkg::*;

    logic        clk;
    logic        rst;
    logic [1:0]  start_r;
    logic [1:0]  force_c;
    logic [3:0]  a_r;
    logic [3:0]  b_r;
    int          sel;
    logic        c0;
    logic        c1;

    int n_checks;
    int n_pass;

    shift_add_mult_ctrl_if #(.N(4)) if0 ();
    shift_add_mult_ctrl_if #(.N(4)) if1 ();

    assign if0.start     = start_r[0];
    assign if0.a         = a_r;
    assign if0.b         = b_r;
    assign if0.add_carry = c0 | force_c[0];
    assign if1.start     = start_r[1];
    assign if1.a         = a_r;
    assign if1.b         = b_r;
    assign if1.add_carry = c1 | force_c[1];

    shift_add_mult_ctrl #(.N(4), .SKIP_ZERO(1'b0)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
    shift_add_mult_ctrl #(.N(4), .SKIP_ZERO(1'b1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
    adder #(.WIDTH(8)) u_add0 (.a(if0.add_a), .b(if0.add_b), .out(if0.add_sum), .carry_out(c0));
    adder #(.WIDTH(8)) u_add1 (.a(if1.add_a), .b(if1.add_b), .out(if1.add_sum), .carry_out(c1));

    logic       w_done, w_busy, w_fault;
    logic [7:0] w_product, w_add_a, w_add_b;
    assign w_done    = (sel == 1) ? if1.done    : if0.done;
    assign w_busy    = (sel == 1) ? if1.busy    : if0.busy;
    assign w_fault   = (sel == 1) ? if1.fault   : if0.fault;
    assign w_product = (sel == 1) ? if1.product : if0.product;
    assign w_add_a   = (sel == 1) ? if1.add_a   : if0.add_a;
    assign w_add_b   = (sel == 1) ? if1.add_b   : if0.add_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Cycles from the accepting edge to the done cycle.
    function automatic int ref_latency(input bit skip, input logic [3:0] bv);
        int hb;
        if (!skip) return N + 1;
        if (bv == 4'd0) return 2;
        hb = 0;
        for (int i = 0; i < 4; i++) begin
            if (bv[i]) hb = i;
        end
        return hb + 2;
    endfunction

    // One operation: start in cycle 0, look for done, check result and idle.
    task automatic run_op(input int s, input logic [3:0] av, input logic [3:0] bv,
                          input bit inj, input bit poke);
        int lat;
        int exp_p;
        int prod_seen;
        exp_p = int'(av) * int'(bv);
        @(negedge clk);
        sel        = s;
        a_r        = av;
        b_r        = bv;
        start_r[s] = 1'b1;
        force_c[s] = inj;
        @(negedge clk);
        start_r[s] = 1'b0;
        check("busy_run", w_busy, 1);
        check("fault_clr", w_fault, 0);
        check("add_a_c1", w_add_a, 0);
        check("add_b_c1", w_add_b, bv[0] ? int'(av) : 0);
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            if (c == 2) force_c[s] = 1'b0;
            if (poke && c == 2) begin
                start_r[s] = 1'b1;
                a_r = ~av;
                b_r = ~bv;
            end
            if (poke && c == 3) start_r[s] = 1'b0;
            if (w_done) begin
                lat = c;
                break;
            end
            @(negedge clk);
        end
        start_r[s] = 1'b0;
        check("latency", lat, ref_latency(s == 1, bv));
        check("product", w_product, exp_p);
        check("fault_done", w_fault, inj);
        prod_seen = int'(w_product);
        @(negedge clk);
        check("busy_after", w_busy, 0);
        check("done_pulse", w_done, 0);
        check("fault_sticky", w_fault, inj);
        check("product_hold", w_product, prod_seen);
    endtask

    initial begin
        int seen;
        int lat1;
        int lat2;
        logic [3:0] ra;
        logic [3:0] rb;
        n_checks = 0;
        n_pass   = 0;
        sel      = 0;
        start_r  = 2'b00;
        force_c  = 2'b00;
        a_r      = 4'd0;
        b_r      = 4'd0;
        rst      = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", if0.busy, 0);
        check("rst_done", if0.done, 0);
        check("rst_product", if0.product, 0);
        check("rst_fault", if0.fault, 0);
        check("rst_add_a", if0.add_a, 0);
        check("rst_add_b", if0.add_b, 0);
        rst = 1'b0;

        run_op(0, 4'd13, 4'd11, 1'b0, 1'b0);
        run_op(0, 4'd15, 4'd15, 1'b0, 1'b0);
        run_op(0, 4'd0,  4'd15, 1'b0, 1'b0);
        run_op(0, 4'd15, 4'd0,  1'b0, 1'b0);
        run_op(0, 4'd3,  4'd5,  1'b0, 1'b1);
        run_op(0, 4'd7,  4'd7,  1'b0, 1'b0);
        run_op(1, 4'd9,  4'd2,  1'b0, 1'b0);
        run_op(1, 4'd9,  4'd0,  1'b0, 1'b0);
        run_op(0, 4'd6,  4'd3,  1'b1, 1'b0);
        run_op(0, 4'd6,  4'd3,  1'b0, 1'b0);
        run_op(1, 4'd5,  4'd9,  1'b1, 1'b0);

        // Fault cleared by reset.
        run_op(0, 4'd2, 4'd1, 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("fault_rst", if0.fault, 0);

        // Reset after two iterations aborts the operation.
        @(negedge clk);
        sel = 0; a_r = 4'd11; b_r = 4'd13; start_r[0] = 1'b1;
        @(negedge clk);
        start_r[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", if0.busy, 0);
        check("abort_done", if0.done, 0);
        check("abort_product", if0.product, 0);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (if0.done) seen++;
        end
        check("abort_no_done", seen, 0);

        // Start held high: next op accepted in the IDLE cycle after DONE.
        @(negedge clk);
        sel = 0; a_r = 4'd5; b_r = 4'd6; start_r[0] = 1'b1;
        lat1 = 0;
        lat2 = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (c == 1) begin
                a_r = 4'd9;
                b_r = 4'd3;
            end
            if (if0.done && lat1 == 0) begin
                lat1 = c;
                check("b2b_prod1", if0.product, 30);
            end else if (if0.done) begin
                lat2 = c;
                start_r[0] = 1'b0;
                check("b2b_prod2", if0.product, 27);
                break;
            end
        end
        start_r[0] = 1'b0;
        check("b2b_first", lat1, N + 1);
        check("b2b_period", lat2 - lat1, N + 2);
        repeat (N + 3) @(negedge clk);

        // Randomized operations on both configurations.
        for (int k = 0; k < 24; k++) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            run_op(k % 2, ra, rb, 1'b0, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/shift_add_mult_ctrl.md
Name: shift_add_mult_ctrl

Overview:
- Sequential controller that computes a 4x4 unsigned product by reusing the existing 8-bit ripple `adder` once per multiplier bit.
- The adder sits outside this block. The controller drives its operands, captures its sum and carry, and runs the shift-add loop.
- Provides a start/busy/done handshake to the top level of the 4x4 multiplier FPGA design.

Parameters:
- N, 4, operand width. 2*N must equal the adder width (8); other values are illegal.
- SKIP_ZERO, 0, when 1: terminate early once the remaining multiplier bits are all zero.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a multiplication; sampled only in IDLE.
- a  input  N  multiplicand, captured on the accepted start.
- b  input  N  multiplier, captured on the accepted start.
- add_a  output  2N  adder operand A; always equal to the accumulator.
- add_b  output  2N  adder operand B; shifted multiplicand when the current bit is 1, else 0.
- add_sum  input  2N  adder out.
- add_carry  input  1  adder carry_out.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse when product is valid.
- product  output  2N  result; held until the next accepted start.
- fault  output  1  sticky; set if add_carry=1 on any accumulate cycle.

Behaviour:
- Reset (rst=1 at a clk edge, any state, including mid-operation):
  - state=IDLE.
  - Accumulator, mcand register, mult register, count, product, busy, done and fault all cleared to 0.
  - add_a=0 and add_b=0.
- States: IDLE, RUN, DONE; 2-bit encoding.
- IDLE:
  - If start=1: mcand<={N'b0,a}, mult<=b, acc<=0, count<=0, fault<=0, go to RUN.
  - If start=0: stay in IDLE. product keeps its last value.
- RUN (one iteration per cycle):
  - Combinational: add_a=acc; add_b = mult[0] ? mcand : 0.
  - At the edge:
    - acc<=add_sum.
    - If add_carry=1 and mult[0]=1, set fault.
    - mcand<=mcand<<1 (bit shifted out of 2N is discarded).
    - mult<=mult>>1, count<=count+1.
  - Exit to DONE when count==N-1 at that edge.
  - Exit to DONE also when SKIP_ZERO=1 and (mult>>1)==0.
- DONE:
  - product<=acc, done=1 for exactly this cycle, busy=1.
  - Next state IDLE.
- Latency: start sampled at edge E; done high in cycle E+N+1 (5 cycles for N=4).
  - With SKIP_ZERO=1, latency is the index of the highest set bit of b plus 2.
  - b=0 takes the minimum, 2 cycles.
- start while busy: ignored, no queuing. a and b are not re-sampled.
- start held high continuously: a new operation is accepted in the IDLE cycle after DONE. Back-to-back throughput is N+2 cycles.
- Arithmetic: unsigned. The max product 225 fits in 8 bits, so a correct adder never produces carry on an accumulate. fault therefore flags an adder defect.
- rst and start in the same cycle: rst wins.

Decomposition:
- Shared package mult_pkg holds:
  - N=4 and PW=2*N.
  - State encoding constants IDLE=2'd0, RUN=2'd1, DONE=2'd2.
- No sub-module inside the controller. The existing adder is instantiated alongside it in the multiplier top level, wired add_a→a, add_b→b, out→add_sum, carry_out→add_carry.
- The bench instantiates both blocks.

Test Plan:
- Reset, then start with a=13, b=11 -> done pulses 5 cycles after start, product=143 (8'h8F), fault=0, busy low the cycle after done.
- a=15, b=15 -> product=225; a=0, b=15 -> product=0; a=15, b=0 -> product=0; all with fault=0.
- Start a=3, b=5; pulse start again with a=7, b=7 two cycles later -> second start ignored, product=15. A later start with 7,7 yields 49.
- Assert rst during RUN after 2 iterations -> next cycle state IDLE, busy=0, done=0, product=0; no done pulse follows.
- SKIP_ZERO=1, a=9, b=2 -> done after 3 cycles, product=18. With b=0 -> done after 2 cycles, product=0.
- Force add_carry=1 on the first accumulate cycle -> fault=1 and stays 1 through done. Cleared by the next accepted start or by rst.
